// File: rtl/uart_sram_loader_if.sv
// UART byte strobe in, SRAM write port out; master = loader, slave = UART/SRAM side.
interface uart_sram_loader_if;
    logic        UART_rx_valid;
    logic [7:0]  UART_rx_data;
    logic [17:0] SRAM_address;
    logic [15:0] SRAM_write_data;
    logic        SRAM_we_n;

    modport master (
        input  UART_rx_valid, UART_rx_data,
        output SRAM_address, SRAM_write_data, SRAM_we_n
    );

    modport slave (
        output UART_rx_valid, UART_rx_data,
        input  SRAM_address, SRAM_write_data, SRAM_we_n
    );
endinterface

// File: rtl/uart_sram_loader.sv
// Packs UART bytes big-endian into 16-bit SRAM words from BASE_ADDR; line silence ends the transfer (LOADER_ODD_PAD_EN pads an odd tail with 8'hFF).
// Latency: low-byte strobe at edge N -> SRAM_we_n low in cycle N+1 -> address advances at N+2; Done at TIMEOUT+1 (even) / TIMEOUT+2 (pad path).
// No backpressure: strobes are accepted in S_WAIT_HIGH, S_WAIT_LOW and S_WRITE, ignored elsewhere.
module uart_sram_loader #(
    parameter logic [17:0] BASE_ADDR = 18'd76800,
    parameter logic [25:0] TIMEOUT   = 26'd50000000
) (
    input  logic                       Clock_50,
    input  logic                       Resetn,
    input  logic                       Enable,
    uart_sram_loader_if.master         bus,
    output logic [17:0]                Word_count,
    output logic [25:0]                UART_timer,
    output logic                       Overflow,
    output logic                       Done
);

`ifdef LOADER_ODD_PAD_EN
    localparam bit PAD_EN = 1'b1;
`else
    localparam bit PAD_EN = 1'b0;
`endif

    typedef enum logic [2:0] {
        S_IDLE, S_WAIT_HIGH, S_WAIT_LOW, S_WRITE, S_PAD, S_DONE
    } state_t;

    state_t      state, next_state;
    logic [17:0] addr_q;
    logic [15:0] wdata_q;
    logic        we_n_q;
    logic        started;   // a byte has arrived since S_IDLE; arms the silence timer
    logic        past_end;  // the word at 18'h3FFFF has been written
    logic        strobe_ok;
    logic        timed_out;
    logic        write_next;
    logic        commit;

    assign bus.SRAM_address    = addr_q;
    assign bus.SRAM_write_data = wdata_q;
    assign bus.SRAM_we_n       = we_n_q;

    always_comb begin
        next_state = state;
        strobe_ok  = bus.UART_rx_valid && Enable &&
                     (state == S_WAIT_HIGH || state == S_WAIT_LOW || state == S_WRITE);
        timed_out  = started && (UART_timer >= TIMEOUT - 26'd1);
        case (state)
            S_IDLE:      if (Enable) next_state = S_WAIT_HIGH;
            S_WAIT_HIGH: begin
                if (strobe_ok)      next_state = S_WAIT_LOW;
                else if (timed_out) next_state = S_DONE;
            end
            S_WAIT_LOW: begin
                if (strobe_ok)      next_state = S_WRITE;
                else if (timed_out) next_state = S_PAD;
            end
            S_WRITE:     next_state = strobe_ok ? S_WAIT_LOW : S_WAIT_HIGH;
            S_PAD:       next_state = S_DONE;
            S_DONE:      next_state = S_IDLE;
            default:     next_state = S_IDLE;
        endcase
        if (!Enable) next_state = S_IDLE;
        write_next = (next_state == S_WRITE) || (PAD_EN && next_state == S_PAD);
        commit     = Enable && !past_end && (state == S_WRITE || (PAD_EN && state == S_PAD));
    end

    always_ff @(posedge Clock_50 or negedge Resetn) begin
        if (!Resetn) begin
            state      <= S_IDLE;
            addr_q     <= BASE_ADDR;
            wdata_q    <= 16'h0000;
            we_n_q     <= 1'b1;
            Word_count <= 18'd0;
            UART_timer <= 26'd0;
            started    <= 1'b0;
            past_end   <= 1'b0;
            Overflow   <= 1'b0;
            Done       <= 1'b0;
        end else begin
            state  <= next_state;
            Done   <= Enable && (state == S_DONE);
            we_n_q <= 1'b1;
            if (write_next) begin
                if (past_end) Overflow <= 1'b1;
                else          we_n_q   <= 1'b0;
            end

            if (strobe_ok) begin
                if (state == S_WAIT_LOW) wdata_q[7:0]  <= bus.UART_rx_data;
                else                     wdata_q[15:8] <= bus.UART_rx_data;
            end
            if (PAD_EN && next_state == S_PAD) wdata_q[7:0] <= 8'hFF;

            if (state == S_IDLE) begin
                UART_timer <= 26'd0;
                started    <= 1'b0;
                // Results of the previous transfer stay visible until Enable restarts it.
                if (Enable) begin
                    addr_q     <= BASE_ADDR;
                    Word_count <= 18'd0;
                    past_end   <= 1'b0;
                end
            end else if (strobe_ok) begin
                UART_timer <= 26'd0;
                started    <= 1'b1;
            end else if (started) begin
                UART_timer <= UART_timer + 26'd1;
            end

            if (commit) begin
                Word_count <= Word_count + 18'd1;
                if (addr_q == 18'h3FFFF) past_end <= 1'b1;
                else                     addr_q   <= addr_q + 18'd1;
            end
        end
    end

endmodule

// File: doc/uart_sram_loader.md
# uart_sram_loader

Upstream stage of the MIC12 decoder top level. It receives the byte stream from the UART receiver and packs bytes big-endian into 16-bit words. It writes the words into external SRAM starting at the compressed-data segment. After a configurable period of line silence it declares the transfer complete, which releases the top-level state machine into decoding. The resulting SRAM layout is identical to the bench's direct SRAM fill: first byte in bits 15:8, words from address 76800 upward.

## Interface
- BASE_ADDR, 18'd76800, first SRAM word address written.
- TIMEOUT, 26'd50000000, idle cycles after the last byte before completion (1 s at 50 MHz).
- Clock_50  in  1  system clock, 50 MHz.
- Resetn  in  1  asynchronous, active-low reset.
- Enable  in  1  level; high = accept bytes; low forces return to S_IDLE at the next edge.
- UART_rx_valid  in  1  single-cycle strobe, new byte available.
- UART_rx_data  in  8  received byte, valid with strobe.
- SRAM_address  out  18  write address.
- SRAM_write_data  out  16  packed word.
- SRAM_we_n  out  1  active-low write enable, low for exactly one cycle per word.
- Word_count  out  18  words written since leaving S_IDLE.
- UART_timer  out  26  current silence counter, exposed for bench forcing.
- Overflow  out  1  sticky; a write was suppressed past address 18'h3FFFF.
- Done  out  1  one-cycle pulse at completion.

## Operation
- States: S_IDLE, S_WAIT_HIGH, S_WAIT_LOW, S_WRITE, S_PAD, S_DONE.
- S_IDLE:
  - Address ← BASE_ADDR, Word_count ← 0, timer ← 0.
  - Go to S_WAIT_HIGH when Enable=1.
- S_WAIT_HIGH:
  - On a strobe, latch the byte into bits 15:8 and go to S_WAIT_LOW.
- S_WAIT_LOW:
  - On a strobe, latch the byte into bits 7:0 and go to S_WRITE.
- S_WRITE:
  - Lasts one cycle: SRAM_we_n=0, current address and word driven.
  - Next cycle: address+1, Word_count+1, go to S_WAIT_HIGH.
  - A strobe arriving in S_WRITE is latched as the next high byte; next state is then S_WAIT_LOW.
- Silence timer:
  - Held at 0 until the first byte after S_IDLE; cleared by every strobe; otherwise increments by 1.
  - When timer == TIMEOUT-1 in S_WAIT_HIGH, go to S_DONE.
  - In S_WAIT_LOW (odd byte count), go to S_PAD.
- S_PAD: see Configuration.
- S_DONE:
  - Done=1 for one cycle, then S_IDLE.
  - Address and Word_count hold until S_IDLE is re-entered with Enable high.
- No byte ever received: wait in S_WAIT_HIGH indefinitely; no timeout.
- Address overflow:
  - A write at address 18'h3FFFF completes.
  - Later words are dropped (SRAM_we_n stays 1), Overflow=1, Word_count frozen.
  - The timeout still completes normally.
- Enable deassert: from any state, go to S_IDLE next cycle. Any partially latched byte is discarded. No Done pulse.

## Timing
- Reset values:
  - SRAM_address=BASE_ADDR, SRAM_write_data=0, SRAM_we_n=1.
  - Word_count=0, UART_timer=0, Overflow=0, Done=0, state S_IDLE.
- Address, data and SRAM_we_n are registered outputs.
- Latency: strobe of the low byte at edge N → SRAM_we_n low during cycle N+1 → address advanced at N+2.
- Done asserts TIMEOUT+1 cycles after the last strobe on the even path, TIMEOUT+2 cycles on the pad path.
- Resetn assertion mid-write: SRAM_we_n goes high immediately (asynchronous); the word is lost.

## Configuration
- LOADER_ODD_PAD_EN defined:
  - S_PAD writes {high byte, 8'hFF} in one SRAM_we_n cycle, increments Word_count, then goes to S_DONE.
  - This matches the bench fill, which pads an odd trailing byte with 8'hFF.
- Undefined:
  - S_PAD performs no write; the trailing byte is discarded and S_PAD goes straight to S_DONE.
  - Word_count excludes the discarded byte.

## Test plan
- Bytes 8'h4D,8'h49,8'h43,8'h31 then silence with TIMEOUT=100 → writes 16'h4D49@76800 and 16'h4331@76801; Word_count=2; Done pulse 101 cycles after the last strobe.
- Three bytes AA,BB,CC, LOADER_ODD_PAD_EN defined → 16'hCCFF written at 76801, Word_count=2. Macro undefined → no third write, Word_count=1.
- Strobe in the same cycle as S_WRITE → byte becomes the next high byte; no bytes lost over 1000 back-to-back bytes spaced 2 cycles apart.
- BASE_ADDR=18'h3FFFE, 6 bytes → writes at 3FFFE and 3FFFF only; Overflow=1; Word_count=2; Done still pulses.
- Force UART_timer to 26'd49999990 after one full word with default TIMEOUT → Done within 10 cycles.
- Resetn low during S_WAIT_LOW → all outputs return to reset values asynchronously. Enable low mid-stream → S_IDLE without a Done pulse.
